// File: rtl/periph_bus_master_pkg.sv
// Shared encodings for periph_bus_master: command opcodes, FSM states and poll gap counter width.
package periph_bus_master_pkg;

    typedef enum logic [1:0] {
        PBM_OP_WR   = 2'b00,
        PBM_OP_RD   = 2'b01,
        PBM_OP_POLL = 2'b10,
        PBM_OP_RSV  = 2'b11
    } pbm_op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_STROBE = 2'b01,
        ST_GAP    = 2'b10,
        ST_RESP   = 2'b11
    } pbm_state_e;

    // POLL_GAP is limited to 0..15
    localparam int GAP_W = 4;

    function automatic logic op_is_read(input logic [1:0] op);
        return op != PBM_OP_WR;
    endfunction

endpackage

// File: rtl/pbm_poll_ctr.sv
// Poll spacing down-counter and, with PBM_POLL_TIMEOUT_EN, the poll read counter that bounds a poll.
module pbm_poll_ctr
    import periph_bus_master_pkg::*;
#(
    parameter int POLL_GAP = 2,
    parameter int TIMEOUT  = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic expired
`ifdef PBM_POLL_TIMEOUT_EN
    ,
    input  logic rd_clr,
    input  logic rd_inc,
    output logic rd_last
`endif
);

    if (POLL_GAP < 0 || POLL_GAP > 15 || TIMEOUT < 1) begin : g_bad_cfg
        $error("pbm_poll_ctr: POLL_GAP must be 0..15 and TIMEOUT at least 1");
    end

    logic [GAP_W-1:0] gap_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gap_cnt <= '0;
        end else if (load) begin
            gap_cnt <= GAP_W'(POLL_GAP);
        end else if (dec && gap_cnt != '0) begin
            gap_cnt <= gap_cnt - 1'b1;
        end
    end

    // Asserted in the last gap cycle so the next strobe is registered in time
    assign expired = (gap_cnt <= GAP_W'(1));

`ifdef PBM_POLL_TIMEOUT_EN
    localparam int RD_W = $clog2(TIMEOUT + 1);

    logic [RD_W-1:0] rd_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_cnt <= '0;
        end else if (rd_clr) begin
            rd_cnt <= '0;
        end else if (rd_inc) begin
            rd_cnt <= rd_cnt + 1'b1;
        end
    end

    // Sampled at the end of a strobe, before that read is counted
    assign rd_last = (rd_cnt == RD_W'(TIMEOUT - 1));
`endif

endmodule

// File: rtl/periph_bus_master.sv
// periph_bus_master: J1 I/O bus initiator running one write/read/poll command at a time.
// Defining PBM_POLL_TIMEOUT_EN bounds a poll to TIMEOUT reads and reports rsp_err on expiry.
module periph_bus_master
    import periph_bus_master_pkg::*;
#(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 16,
    parameter int POLL_GAP = 2,
    parameter int TIMEOUT  = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              io_cs,
    output logic [ADDR_W-1:0] io_addr,
    output logic              io_rd,
    output logic              io_wr,
    output logic [DATA_W-1:0] io_dout,
    input  logic [DATA_W-1:0] io_din
);

    pbm_state_e        state;
    pbm_op_e           op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              accept;
    logic              gap_expired;
    logic              poll_hit;
    logic              poll_give_up;
    logic              poll_retry;

    function automatic logic poll_satisfied(input logic [DATA_W-1:0] din,
                                            input logic [DATA_W-1:0] mask);
        return (mask == '0) || ((din & mask) != '0);
    endfunction

    assign accept     = (state == ST_IDLE) && cmd_valid && cmd_ready;
    assign poll_hit   = poll_satisfied(io_din, data_q);
    assign poll_retry = (state == ST_STROBE) && (op_q == PBM_OP_POLL) && !poll_hit && !poll_give_up;

    // Command latch: only loaded on the IDLE handshake, so busy-time input changes are ignored
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q   <= pbm_op_e'(cmd_op);
            addr_q <= cmd_addr;
            data_q <= cmd_data;
        end
    end

    pbm_poll_ctr #(
        .POLL_GAP (POLL_GAP),
        .TIMEOUT  (TIMEOUT)
    ) u_poll_ctr (
        .clk     (clk),
        .rst     (rst),
        .load    (poll_retry),
        .dec     (state == ST_GAP),
        .expired (gap_expired)
`ifdef PBM_POLL_TIMEOUT_EN
        ,
        .rd_clr  (accept),
        .rd_inc  ((state == ST_STROBE) && (op_q == PBM_OP_POLL)),
        .rd_last (poll_give_up)
`endif
    );

`ifndef PBM_POLL_TIMEOUT_EN
    assign poll_give_up = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            io_cs     <= 1'b0;
            io_addr   <= '0;
            io_rd     <= 1'b0;
            io_wr     <= 1'b0;
            io_dout   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        cmd_ready <= 1'b0;
                        if (cmd_op == PBM_OP_RSV) begin
                            state     <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_data  <= '0;
                        end else begin
                            state   <= ST_STROBE;
                            io_cs   <= 1'b1;
                            io_addr <= cmd_addr;
                            io_wr   <= (cmd_op == PBM_OP_WR);
                            io_rd   <= op_is_read(cmd_op);
                            io_dout <= (cmd_op == PBM_OP_WR) ? cmd_data : '0;
                        end
                    end
                end
                ST_STROBE: begin
                    io_cs   <= 1'b0;
                    io_addr <= '0;
                    io_rd   <= 1'b0;
                    io_wr   <= 1'b0;
                    io_dout <= '0;
                    // io_din was registered by the peripheral on the mid-strobe falling edge
                    if (op_q != PBM_OP_POLL || poll_hit || poll_give_up) begin
                        state     <= ST_RESP;
                        rsp_valid <= 1'b1;
                        rsp_data  <= (op_q == PBM_OP_WR) ? '0 : io_din;
                        rsp_err   <= (op_q == PBM_OP_POLL) && !poll_hit;
                    end else if (POLL_GAP == 0) begin
                        state   <= ST_STROBE;
                        io_cs   <= 1'b1;
                        io_addr <= addr_q;
                        io_rd   <= 1'b1;
                    end else begin
                        state <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_expired) begin
                        state   <= ST_STROBE;
                        io_cs   <= 1'b1;
                        io_addr <= addr_q;
                        io_rd   <= 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state     <= ST_IDLE;
                        rsp_valid <= 1'b0;
                        rsp_data  <= '0;
                        rsp_err   <= 1'b0;
                        cmd_ready <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_periph_bus_master.sv
// Self-checking bench for periph_bus_master with a divider-style peripheral and a register-file reference.
`timescale 1ns/1ps
module tb_periph_bus_master;

    localparam int ADDR_W     = 4;
    localparam int DATA_W     = 16;
    localparam int POLL_GAP   = 2;
    localparam int TIMEOUT    = 8;
    localparam int DONE_AFTER = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [1:0]        cmd_op = 2'b00;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [DATA_W-1:0] cmd_data = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;
    logic              io_cs;
    logic [ADDR_W-1:0] io_addr;
    logic              io_rd;
    logic              io_wr;
    logic [DATA_W-1:0] io_dout;
    logic [DATA_W-1:0] io_din = '0;

    periph_bus_master #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .POLL_GAP(POLL_GAP), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .io_cs(io_cs), .io_addr(io_addr), .io_rd(io_rd),
        .io_wr(io_wr), .io_dout(io_dout), .io_din(io_din)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Peripheral: A at 0x0, B at 0x2, init at 0x4, status at 0x6 (done after DONE_AFTER reads), C at 0x8
    logic [DATA_W-1:0] regs [16] = '{default: '0};
    logic [DATA_W-1:0] div_c = '0;
    int status_reads = 0;

    always @(negedge clk) begin
        if (io_cs && io_wr) begin
            regs[io_addr] = io_dout;
            if (io_addr == 4'h4) begin
                status_reads = 0;
                div_c = regs[0] / regs[2];
            end
        end
        if (io_cs && io_rd) begin
            case (io_addr)
                4'h6: begin
                    status_reads++;
                    io_din <= (status_reads >= DONE_AFTER) ? 16'h0001 : 16'h0000;
                end
                4'h8:    io_din <= div_c;
                default: io_din <= regs[io_addr];
            endcase
        end
    end

    // Bus monitor
    int                strobe_cyc[$];
    logic [ADDR_W-1:0] last_addr = '0;
    logic [DATA_W-1:0] last_dout = '0;
    logic              last_wr = 1'b0;
    logic              last_rd = 1'b0;
    int                bus_viol = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (io_cs) begin
                strobe_cyc.push_back(cyc);
                last_addr = io_addr;
                last_dout = io_dout;
                last_wr   = io_wr;
                last_rd   = io_rd;
                if (io_wr == io_rd) bus_viol++;
                if (cmd_ready || rsp_valid) bus_viol++;
                if (io_rd && io_dout != '0) bus_viol++;
            end else if (io_rd || io_wr || io_addr != '0 || io_dout != '0) begin
                bus_viol++;
            end
        end
    end

    // Reference model of the register file as the master should leave it
    logic [DATA_W-1:0] ref_regs [16] = '{default: '0};

    task automatic do_cmd(input logic [1:0] op, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] data, input string name,
                          output logic [DATA_W-1:0] rdata, output logic rerr,
                          output int lat, output int nstrobe);
        int t0;
        int waited;
        strobe_cyc.delete();
        rdata = '0; rerr = 1'b0; lat = -1; nstrobe = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_data = data;
        waited = 0;
        while (!cmd_ready && waited < 100) begin @(negedge clk); waited++; end
        if (!cmd_ready) begin
            check({name, "_accept"}, 32'(cmd_ready), 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        t0 = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op = 2'($urandom); cmd_addr = ADDR_W'($urandom); cmd_data = DATA_W'($urandom);
        waited = 0;
        while (!rsp_valid && waited < 300) begin @(negedge clk); waited++; end
        if (!rsp_valid) begin
            check({name, "_rsp_timeout"}, 32'(rsp_valid), 32'd1);
            return;
        end
        lat = cyc - t0;
        rdata = rsp_data;
        rerr = rsp_err;
        nstrobe = strobe_cyc.size();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        if (op == 2'b00 && !rerr) ref_regs[addr] = data;
    endtask

    function automatic int spacing_bad();
        int bad = 0;
        for (int i = 1; i < strobe_cyc.size(); i++)
            if (strobe_cyc[i] - strobe_cyc[i-1] != POLL_GAP + 1) bad++;
        return bad;
    endfunction

    typedef struct {
        logic [1:0]        op;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [DATA_W-1:0] exp_data;
        logic              exp_err;
        int                exp_strobes;
        string             name;
    } vec_t;

    function automatic int exp_latency(input logic [1:0] op, input int strobes);
        if (op == 2'b11) return 1;
        return 2 + (strobes - 1) * (POLL_GAP + 1);
    endfunction

    vec_t tbl [10];

    initial begin
        logic [DATA_W-1:0] rd;
        logic              re;
        int                lat;
        int                ns;
        int                hold_bad;
        logic [DATA_W-1:0] d0;

        tbl[0] = '{2'b00, 4'h0, 16'h0064, 16'h0000, 1'b0, 1, "wr_A"};
        tbl[1] = '{2'b00, 4'h2, 16'h0004, 16'h0000, 1'b0, 1, "wr_B"};
        tbl[2] = '{2'b00, 4'h4, 16'h0001, 16'h0000, 1'b0, 1, "wr_init"};
        tbl[3] = '{2'b10, 4'h6, 16'h0001, 16'h0001, 1'b0, 5, "poll_done"};
        tbl[4] = '{2'b01, 4'h8, 16'h7777, 16'h0019, 1'b0, 1, "rd_C"};
        tbl[5] = '{2'b11, 4'h3, 16'hFFFF, 16'h0000, 1'b1, 0, "op_rsv"};
        tbl[6] = '{2'b00, 4'hA, 16'hBEEF, 16'h0000, 1'b0, 1, "wr_A_reg"};
        tbl[7] = '{2'b01, 4'hA, 16'h1234, 16'hBEEF, 1'b0, 1, "rd_A_reg"};
        tbl[8] = '{2'b10, 4'hA, 16'h0000, 16'hBEEF, 1'b0, 1, "poll_mask0"};
        tbl[9] = '{2'b10, 4'hA, 16'h8000, 16'hBEEF, 1'b0, 1, "poll_hit_first"};

        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ctrl", {26'd0, cmd_ready, rsp_valid, rsp_err, io_cs, io_rd, io_wr}, 32'h20);
        check("rst_addr_dout", {12'd0, io_addr, io_dout}, 32'h0);
        check("rst_rsp_data", 32'(rsp_data), 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            do_cmd(tbl[i].op, tbl[i].addr, tbl[i].data, tbl[i].name, rd, re, lat, ns);
            check({tbl[i].name, "_data"}, 32'(rd), 32'(tbl[i].exp_data));
            check({tbl[i].name, "_err"}, 32'(re), 32'(tbl[i].exp_err));
            check({tbl[i].name, "_strobes"}, ns, tbl[i].exp_strobes);
            check({tbl[i].name, "_latency"}, lat, exp_latency(tbl[i].op, tbl[i].exp_strobes));
            if (tbl[i].op == 2'b00) begin
                check({tbl[i].name, "_bus"}, {last_wr, last_rd, 10'd0, last_addr, last_dout},
                      {1'b1, 1'b0, 10'd0, tbl[i].addr, tbl[i].data});
            end else if (tbl[i].op != 2'b11) begin
                check({tbl[i].name, "_bus"}, {last_wr, last_rd, 10'd0, last_addr, last_dout},
                      {1'b0, 1'b1, 10'd0, tbl[i].addr, 16'h0});
            end
            if (tbl[i].exp_strobes > 1) check({tbl[i].name, "_spacing"}, spacing_bad(), 0);
        end

        // Response held off for 10 cycles while the next command waits on the port
        strobe_cyc.delete();
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_addr = 4'hA; cmd_data = 16'h0;
        @(negedge clk);
        cmd_op = 2'b00; cmd_addr = 4'hD; cmd_data = 16'h5555;
        @(negedge clk);
        check("hold_first_valid", 32'(rsp_valid), 32'd1);
        d0 = rsp_data;
        hold_bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_data !== d0 || !rsp_valid || cmd_ready) hold_bad++;
        end
        check("hold_stable", hold_bad, 0);
        check("hold_data", 32'(d0), 32'hBEEF);
        check("hold_no_strobes", strobe_cyc.size(), 1);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("hold_ready_after_hs", {31'd0, cmd_ready}, 32'd1);
        check("hold_strobes_after_hs", strobe_cyc.size(), 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("next_cmd_strobe", {io_cs, io_wr, 10'd0, io_addr, io_dout}, {1'b1, 1'b1, 10'd0, 4'hD, 16'h5555});
        repeat (2) @(negedge clk);
        check("next_cmd_rsp", {rsp_valid, rsp_err, 14'd0, rsp_data}, {1'b1, 1'b0, 30'd0});
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        ref_regs[4'hD] = 16'h5555;

        // Randomized commands against the register-file reference
        for (int n = 0; n < 40; n++) begin
            logic [1:0]        op;
            logic [ADDR_W-1:0] a;
            logic [DATA_W-1:0] d;
            logic [DATA_W-1:0] ed;
            logic              ee;
            int                es;
            op = 2'($urandom_range(0, 3));
            a  = ADDR_W'($urandom_range(13, 15));
            d  = DATA_W'($urandom);
            if (op == 2'b10) begin
                if (ref_regs[a] == '0 || $urandom_range(0, 3) == 0) d = '0;
                else begin
                    d = DATA_W'($urandom) & ref_regs[a];
                    if (d == '0) d = ref_regs[a];
                end
            end
            case (op)
                2'b00:   begin ed = '0;          ee = 1'b0; es = 1; end
                2'b11:   begin ed = '0;          ee = 1'b1; es = 0; end
                default: begin ed = ref_regs[a]; ee = 1'b0; es = 1; end
            endcase
            do_cmd(op, a, d, "rnd", rd, re, lat, ns);
            check("rnd_data", 32'(rd), 32'(ed));
            check("rnd_err_strobes", {31'(ns), re}, {31'(es), ee});
            if (op == 2'b00) check("rnd_wr_bus", {12'd0, last_addr, last_dout}, {12'd0, a, d});
        end

        // Reset asserted in the middle of a write strobe
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_addr = 4'hC; cmd_data = 16'h1234;
        @(posedge clk);
        #1 check("rst_mid_strobe_pre", {30'd0, io_cs, io_wr}, 32'd3);
        @(negedge clk);
        cmd_valid = 1'b0;
        #1 rst = 1'b1;
        #1 check("rst_mid_strobe_async", {29'd0, io_cs, io_wr, io_rd}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_strobe_idle", {30'd0, cmd_ready, rsp_valid}, 32'd2);
        do_cmd(2'b01, 4'hA, 16'h0, "rd_after_rst", rd, re, lat, ns);
        check("rd_after_rst_data", 32'(rd), 32'hBEEF);

`ifdef PBM_POLL_TIMEOUT_EN
        do_cmd(2'b10, 4'hB, 16'h0001, "poll_timeout", rd, re, lat, ns);
        check("poll_timeout_strobes", ns, TIMEOUT);
        check("poll_timeout_err", {31'd0, re}, 32'd1);
        check("poll_timeout_data", 32'(rd), 32'h0);
        check("poll_timeout_spacing", spacing_bad(), 0);
`endif

        repeat (2) @(negedge clk);
        check("bus_protocol", bus_viol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

endmodule
